// File: rtl/pipelined_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_shifter
//
// Pipelined barrel shifter with valid/ready handshakes on both sides. Each
// pipeline stage k applies one shift layer of 2^k positions, gated by bit k
// of the shift amount. An opaque tag travels with every operation. Bubbles
// collapse: an empty stage always accepts from the stage behind it, even
// while the output is stalled.
//
// Parameters:
//   WIDTH    data width (power of two, >= 2)
//   TAG_W    width of the pass-through tag
//   SHAMT_W  log2(WIDTH), derived; also the pipeline depth LAT
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, clears all pipeline state
//   in_valid   upstream presents an operation
//   in_ready   shifter accepts this cycle (low while reset is high)
//   in_data    operand
//   in_shamt   shift amount 0..WIDTH-1
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 ROL
//   in_tag     carried unchanged to out_tag
//   out_valid  out_data/out_tag hold a result
//   out_ready  downstream accepts the result this cycle
//   out_data   shifted result (straight from the last stage register)
//   out_tag    tag of this result
//   busy       at least one stage holds a valid entry
// ---------------------------------------------------------------------------
module pipelined_shifter #(
    parameter  int WIDTH   = 32,
    parameter  int TAG_W   = 5,
    localparam int SHAMT_W = $clog2(WIDTH),
    localparam int LAT     = SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    // One shift layer by a fixed distance s. For SRA the MSB is still the
    // original sign because earlier layers never change it.
    function automatic logic [WIDTH-1:0] shift_layer(input logic [WIDTH-1:0] d,
                                                     input op_e op,
                                                     input int s);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << s;
            OP_SRL:  r = d >> s;
            OP_SRA:  r = $unsigned($signed(d) >>> s);
            default: r = (d << s) | (d >> (WIDTH - s));
        endcase
        return r;
    endfunction

    logic [LAT-1:0]     valid_q;
    logic [LAT-1:0]     adv;
    logic [WIDTH-1:0]   data_q [LAT];
    logic [TAG_W-1:0]   tag_q  [LAT];
    op_e                op_q   [LAT];
    // Stage k keeps only the shamt bits still to be applied, right-aligned.
    logic [SHAMT_W-1:0] sh_q   [LAT];

    // A stage may load when it is empty or when everything downstream of it
    // moves; the last stage moves when the output is empty or taken.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        adv          = '0;
        adv[LAT-1]   = !valid_q[LAT-1] || out_ready;
        for (int k = LAT - 2; k >= 0; k--) begin
            adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    assign in_ready  = adv[0] && !reset;
    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign busy      = |valid_q;

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int S = 1 << k;

        logic               v_in;
        logic [WIDTH-1:0]   d_in;
        op_e                op_in;
        logic [SHAMT_W-1:0] sh_in;
        logic [TAG_W-1:0]   t_in;
        logic [WIDTH-1:0]   d_shift;

        if (k == 0) begin : g_head
            assign v_in  = in_valid && in_ready;
            assign d_in  = in_data;
            assign op_in = op_e'(in_op);
            assign sh_in = in_shamt;
            assign t_in  = in_tag;
        end else begin : g_link
            assign v_in  = valid_q[k-1];
            assign d_in  = data_q[k-1];
            assign op_in = op_q[k-1];
            assign sh_in = sh_q[k-1];
            assign t_in  = tag_q[k-1];
        end

        assign d_shift = sh_in[0] ? shift_layer(d_in, op_in, S) : d_in;

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its neighbour's pre-edge value.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_q[k] <= 1'b0;
                // NOTE: payload registers are reset too, because out_data and
                // out_tag are driven directly from them and must read zero
                // while reset is held.
                data_q[k]  <= '0;
                tag_q[k]   <= '0;
                op_q[k]    <= OP_SLL;
                sh_q[k]    <= '0;
            end else if (adv[k]) begin
                valid_q[k] <= v_in;
                // Payload loads only with a valid entry, so the output holds
                // its last result while out_valid is low.
                if (v_in) begin
                    data_q[k] <= d_shift;
                    tag_q[k]  <= t_in;
                    op_q[k]   <= op_in;
                    sh_q[k]   <= sh_in >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_shifter
//
// Bench for pipelined_shifter: a WIDTH=32 instance (LAT=5) and a WIDTH=8
// instance (LAT=3). Expected results come from an arithmetic shift model and
// a queue scoreboard holding accepted operations in order.
// ---------------------------------------------------------------------------
module tb_pipelined_shifter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // WIDTH=32 instance
    logic        iv32 = 1'b0, ir32, ov32, ordy32 = 1'b1, busy32;
    logic [31:0] id32 = '0, od32;
    logic [4:0]  sh32 = '0, tg32 = '0, ot32;
    logic [1:0]  op32 = '0;

    // WIDTH=8 instance
    logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, busy8;
    logic [7:0]  id8 = '0, od8;
    logic [2:0]  sh8 = '0;
    logic [4:0]  tg8 = '0, ot8;
    logic [1:0]  op8 = '0;

    pipelined_shifter #(.WIDTH(32), .TAG_W(5)) u_dut32 (
        .clock(clock), .reset(reset),
        .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_shamt(sh32),
        .in_op(op32), .in_tag(tg32),
        .out_valid(ov32), .out_ready(ordy32), .out_data(od32), .out_tag(ot32),
        .busy(busy32)
    );

    pipelined_shifter #(.WIDTH(8), .TAG_W(5)) u_dut8 (
        .clock(clock), .reset(reset),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_shamt(sh8),
        .in_op(op8), .in_tag(tg8),
        .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_tag(ot8),
        .busy(busy8)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [4:0]  prev_tag   = '0;

    // Single-step shift of a w-bit value, computed directly from the mode
    // definitions (no layering).
    function automatic logic [31:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] d, input int sh);
        logic [31:0] mask;
        logic [31:0] x;
        logic [31:0] r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        x    = d & mask;
        case (op)
            2'd0: r = x << sh;
            2'd1: r = x >> sh;
            2'd2: begin
                r = x >> sh;
                if (x[w-1]) r = r | (mask & ~(mask >> sh));
            end
            default: r = (sh == 0) ? x : ((x << sh) | (x >> (w - sh)));
        endcase
        return r & mask;
    endfunction

    // One cycle on the 32-bit instance with scoreboard checking. Called at
    // posedge+1, returns at the next posedge+1.
    task automatic step32(input logic v, input logic r, input logic [1:0] op,
                          input logic [31:0] d, input logic [4:0] sh,
                          input logic [4:0] tag, output logic acc,
                          output logic rdy);
        exp_t e;
        logic exp_rdy;
        iv32 = v; ordy32 = r; op32 = op; id32 = d; sh32 = sh; tg32 = tag;
        #1;
        exp_rdy = !(sb.size() == 5 && !r);
        n_checks++;
        if (ir32 !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b (occupancy %0d)", ir32, exp_rdy, sb.size());
        end
        n_checks++;
        if (busy32 !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL busy: got %b expected %b", busy32, sb.size() != 0);
        end
        if (prev_stall) begin
            n_checks++;
            if (ov32 !== 1'b1 || od32 !== prev_data || ot32 !== prev_tag) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b %h/%0d expected v=1 %h/%0d",
                         ov32, od32, ot32, prev_data, prev_tag);
            end
        end
        if (ov32 === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_out: got result %h/%0d expected none", od32, ot32);
            end else if (r) begin
                e = sb.pop_front();
                n_out++;
                if (od32 !== e.data || ot32 !== e.tag) begin
                    n_fail++;
                    $display("FAIL result: got %h/%0d expected %h/%0d", od32, ot32, e.data, e.tag);
                end
            end
        end
        rdy = ir32;
        acc = v && ir32;
        if (acc) sb.push_back('{data: model(32, op, d, int'(sh)), tag: tag});
        prev_stall = ov32 && !r;
        prev_data  = od32;
        prev_tag   = ot32;
        @(posedge clock); #1;
    endtask

    // Issue one op into an idle 32-bit pipeline and measure edges to out_valid.
    task automatic send32(input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [4:0] tag,
                          output logic [31:0] rd, output logic [4:0] rt,
                          output int lat);
        iv32 = 1'b1; ordy32 = 1'b1; op32 = op; id32 = d; sh32 = sh; tg32 = tag;
        #1;
        n_checks++;
        if (ir32 !== 1'b1) begin
            n_fail++;
            $display("FAIL send32_ready: got %b expected 1", ir32);
        end
        @(posedge clock); #1;
        iv32 = 1'b0;
        lat  = 1;
        while (ov32 !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        if (ov32 !== 1'b1) lat = -1;
        rd = od32;
        rt = ot32;
    endtask

    task automatic send8(input logic [1:0] op, input logic [7:0] d,
                         input logic [2:0] sh, input logic [4:0] tag,
                         output logic [7:0] rd, output logic [4:0] rt,
                         output int lat);
        iv8 = 1'b1; ordy8 = 1'b1; op8 = op; id8 = d; sh8 = sh; tg8 = tag;
        #1;
        n_checks++;
        if (ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL send8_ready: got %b expected 1", ir8);
        end
        @(posedge clock); #1;
        iv8 = 1'b0;
        lat = 1;
        while (ov8 !== 1'b1 && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        if (ov8 !== 1'b1) lat = -1;
        rd = od8;
        rt = ot8;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (ov32 !== 1'b0 || od32 !== 32'h0 || ot32 !== 5'h0 || busy32 !== 1'b0 || ir32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state32: got v=%b d=%h t=%0d busy=%b rdy=%b expected all 0",
                     ov32, od32, ot32, busy32, ir32);
        end
        n_checks++;
        if (ov8 !== 1'b0 || od8 !== 8'h0 || busy8 !== 1'b0 || ir8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state8: got v=%b d=%h busy=%b rdy=%b expected all 0",
                     ov8, od8, busy8, ir8);
        end
        @(posedge clock);
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if (ir32 !== 1'b1 || ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b/%b expected 1/1", ir32, ir8);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops  [9];
        logic [31:0] din  [9];
        logic [4:0]  shs  [9];
        logic [31:0] want [9];
        logic [31:0] rd;
        logic [4:0]  rt;
        logic [4:0]  tag;
        int          lat;
        ops[0] = 2'd0; din[0] = 32'h0000_0001; shs[0] = 5'd31; want[0] = 32'h8000_0000;
        ops[1] = 2'd2; din[1] = 32'h8000_0000; shs[1] = 5'd4;  want[1] = 32'hF800_0000;
        ops[2] = 2'd1; din[2] = 32'h8000_0000; shs[2] = 5'd4;  want[2] = 32'h0800_0000;
        ops[3] = 2'd2; din[3] = 32'h7FFF_FFFF; shs[3] = 5'd31; want[3] = 32'h0000_0000;
        ops[4] = 2'd3; din[4] = 32'h8000_0001; shs[4] = 5'd1;  want[4] = 32'h0000_0003;
        for (int i = 0; i < 4; i++) begin
            ops[5+i] = 2'(i); din[5+i] = 32'hDEAD_BEEF; shs[5+i] = 5'd0; want[5+i] = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < 9; i++) begin
            tag = (i == 0) ? 5'd7 : 5'(i + 10);
            send32(ops[i], din[i], shs[i], tag, rd, rt, lat);
            n_checks++;
            if (rd !== want[i] || rt !== tag) begin
                n_fail++;
                $display("FAIL directed[%0d]: got %h/%0d expected %h/%0d", i, rd, rt, want[i], tag);
            end
            n_checks++;
            if (lat != 5) begin
                n_fail++;
                $display("FAIL latency32[%0d]: got %0d expected 5", i, lat);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back;
        int   next = 0;
        int   cyc  = 0;
        int   start;
        logic saw_low = 1'b0;
        logic acc, rdy;
        start      = n_out;
        prev_stall = 1'b0;
        while ((n_out - start) < 10 && cyc < 80) begin
            step32(next < 10, !(cyc >= 4 && cyc < 11), 2'($urandom_range(0, 3)), $urandom,
                   5'($urandom_range(0, 31)), 5'(next), acc, rdy);
            if (acc) next++;
            if (!rdy) saw_low = 1'b1;
            cyc++;
        end
        iv32 = 1'b0;
        n_checks++;
        if ((n_out - start) != 10 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs (%0d pending) expected 10 (0)", n_out - start, sb.size());
        end
        n_checks++;
        if (saw_low !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_backpressure: got in_ready low=%b expected 1", saw_low);
        end
    endtask

    task automatic test_random_stream;
        logic acc, rdy;
        int   tag = 0;
        int   cyc = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step32($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                   $urandom, 5'($urandom_range(0, 31)), 5'(tag), acc, rdy);
            if (acc) tag++;
        end
        while (sb.size() != 0 && cyc < 50) begin
            step32(1'b0, 1'b1, 2'd0, 32'h0, 5'd0, 5'd0, acc, rdy);
            cyc++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_reset_midflight;
        int bad = 0;
        ordy32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iv32 = 1'b1; op32 = 2'($urandom_range(0, 3)); id32 = $urandom;
            sh32 = 5'($urandom_range(0, 31)); tg32 = 5'(20 + i);
            @(posedge clock); #1;
        end
        iv32 = 1'b0;
        n_checks++;
        if (busy32 !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_busy: got %b expected 1", busy32);
        end
        #2 reset = 1'b1;
        iv32 = 1'b1;
        #1;
        n_checks++;
        if (ov32 !== 1'b0 || busy32 !== 1'b0 || ir32 !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset: got v=%b busy=%b rdy=%b expected 0/0/0", ov32, busy32, ir32);
        end
        @(posedge clock); #2;
        reset = 1'b0;
        iv32  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (ov32 !== 1'b0 || busy32 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midflight_ghost: got %0d cycles with output/busy expected 0", bad);
        end
        sb.delete();
        prev_stall = 1'b0;
    endtask

    task automatic test_width8;
        logic [7:0] rd;
        logic [4:0] rt;
        logic [1:0] op;
        logic [7:0] d;
        logic [2:0] sh;
        logic [7:0] want;
        int         lat;
        send8(2'd3, 8'h81, 3'd3, 5'd1, rd, rt, lat);
        n_checks++;
        if (rd !== 8'h0C || rt !== 5'd1 || lat != 3) begin
            n_fail++;
            $display("FAIL w8_rol: got %h/%0d lat %0d expected 0c/1 lat 3", rd, rt, lat);
        end
        send8(2'd2, 8'h90, 3'd2, 5'd2, rd, rt, lat);
        n_checks++;
        if (rd !== 8'hE4 || rt !== 5'd2 || lat != 3) begin
            n_fail++;
            $display("FAIL w8_sra: got %h/%0d lat %0d expected e4/2 lat 3", rd, rt, lat);
        end
        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            sh = 3'($urandom_range(0, 7));
            want = 8'(model(8, op, {24'h0, d}, int'(sh)));
            send8(op, d, sh, 5'(i), rd, rt, lat);
            n_checks++;
            if (rd !== want || rt !== 5'(i) || lat != 3) begin
                n_fail++;
                $display("FAIL w8_random[%0d]: got %h/%0d lat %0d expected %h/%0d lat 3",
                         i, rd, rt, lat, want, i);
            end
        end
        @(posedge clock); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream();
        test_reset_midflight();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
